// File: rtl/zmips_pkg.sv
// Shared encodings for the zmips multiply/divide unit: operation codes and
// the sequencer state type.
package zmips_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // Signed variants have op[0] clear, divides have op[1] set.
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/zmips_cond_neg.sv
// Conditional two's-complement negator: out = neg ? -in : in.
module zmips_cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? ((~val_i) + WIDTH'(1)) : val_i;

endmodule

// File: rtl/zmips_muldiv.sv
// Radix-2 iterative multiply/divide unit owning HI/LO, start/busy/done handshake.
// Optional macro ZMIPS_MULDIV_EARLY_OUT_EN: multiply finishes once remaining multiplier bits are zero.
module zmips_muldiv
  import zmips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q, divz_q, dzo_q;
  logic             neg_res_q, neg_rem_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] acc_q, mq_q, md_q;

  logic             accept, sgn_in, div0_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_d, mq_d;
  logic             early_out;
  logic [2*WIDTH-1:0] early_prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign accept  = start && (state_q == IDLE);
  assign sgn_in  = md_is_signed(op);
  assign div0_in = md_is_div(op) && (b == '0);

  zmips_cond_neg #(.WIDTH(WIDTH)) u_mag_a (.val_i(a), .neg_i(sgn_in & a[WIDTH-1]), .val_o(a_mag));
  zmips_cond_neg #(.WIDTH(WIDTH)) u_mag_b (.val_i(b), .neg_i(sgn_in & b[WIDTH-1]), .val_o(b_mag));

  // One iteration: right-shifting shift-add for multiply, restoring shift-subtract for divide.
  assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, md_q} : '0);
  assign div_shift = {acc_q, mq_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, md_q});
  assign div_diff  = div_shift[WIDTH-1:0] - md_q;

  always_comb begin
    acc_d = mul_sum[WIDTH:1];
    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
    if (div_q) begin
      acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
      mq_d  = {mq_q[WIDTH-2:0], div_ge};
    end
  end

`ifdef ZMIPS_MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] rem_mask;
  // Low cnt_q bits of mq_q are the multiplier bits not yet consumed.
  assign rem_mask   = {WIDTH{1'b1}} >> (CW'(WIDTH) - cnt_q);
  assign early_out  = (state_q == RUN) && !div_q && ((mq_q & rem_mask) == '0);
  assign early_prod = {acc_q, mq_q} >> cnt_q;
`else
  assign early_out  = 1'b0;
  assign early_prod = {acc_q, mq_q};
`endif

  zmips_cond_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.val_i({acc_q, mq_q}), .neg_i(neg_res_q), .val_o(prod_fix));
  zmips_cond_neg #(.WIDTH(WIDTH))   u_fix_quo  (.val_i(mq_q),  .neg_i(neg_res_q), .val_o(quo_fix));
  zmips_cond_neg #(.WIDTH(WIDTH))   u_fix_rem  (.val_i(acc_q), .neg_i(neg_rem_q), .val_o(rem_fix));

  // Datapath registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q <= '0;
      md_q  <= b_mag;
      mq_q  <= div0_in ? a : a_mag;
    end else if (state_q == RUN) begin
      if (early_out) begin
        {acc_q, mq_q} <= early_prod;
      end else begin
        acc_q <= acc_d;
        mq_q  <= mq_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      divz_q    <= 1'b0;
      dzo_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_hi) hi_q <= wdata;
          if (wr_lo) lo_q <= wdata;
          if (start) begin
            div_q     <= md_is_div(op);
            divz_q    <= div0_in;
            dzo_q     <= 1'b0;
            neg_res_q <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= sgn_in & a[WIDTH-1];
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= div0_in ? FIX : RUN;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (early_out || (cnt_q == CW'(1))) state_q <= FIX;
        end
        FIX: begin
          if (divz_q) begin
            hi_q <= mq_q;
            lo_q <= '1;
          end else if (div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          dzo_q   <= divz_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dzo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_zmips_muldiv.sv
// Scoreboard bench for zmips_muldiv (WIDTH=32): driver pushes expected HI/LO/div_zero/done-edge, monitor pops on done.
module tb_zmips_muldiv;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        rst, start, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          dedge;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   ecnt = 0;
  int   nvec = 0;
  int   nmis = 0;

  zmips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.nm, "_hi"},    hi, mon_e.hi);
        check({mon_e.nm, "_lo"},    lo, mon_e.lo);
        check({mon_e.nm, "_dz"},    {31'd0, div_zero}, {31'd0, mon_e.dz});
        check({mon_e.nm, "_cycle"}, ecnt, mon_e.dedge);
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge (cycle 0).
  task automatic issue(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz,
                       input int lat, input string nm);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = edz; e.dedge = ecnt + lat; e.nm = nm;
    sb.push_back(e);
    op = o; a = xa; b = xb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) check({nm, "_done_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({nm, "_drain_timeout"}, 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = MULTU; a = '0; b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz",   {31'd0, div_zero}, 32'd0);
    check("rst_hi",   hi, 32'd0);
    check("rst_lo",   lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full-scale unsigned multiply plus busy window length.
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, "multu_max");
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("multu_busy_cycles", n, 33);
    drain("multu_max");

    issue(MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, "mult_neg");
    drain("mult_neg");

    // Signed divide, then unsigned divide accepted in the done cycle.
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, "div_neg");
    wait_done("div_neg");
    issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, "divu_b2b");
    drain("divu_b2b");

    issue(DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34, "div_negdivisor");
    drain("div_negdivisor");

    issue(DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2, "div_zero");
    drain("div_zero");
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34, "div_ovf");
    drain("div_ovf");

    // Direct HI write while idle.
    wr_hi = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi", hi, 32'hAAAA_5555);

    // LO write together with an accepted start: visible during busy, then overwritten.
    wr_lo = 1'b1; wdata = 32'h0000_0055;
    issue(MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34, "mtlo_with_start");
    wr_lo = 1'b0;
    check("mtlo_with_start_lo_busy", lo, 32'h0000_0055);
    drain("mtlo_with_start");

    // Start and LO write while busy are both ignored.
    issue(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34, "busy_ignore");
    repeat (4) @(negedge clk);
    start = 1'b1; op = MULTU; a = 32'd9; b = 32'd5;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    wr_lo = 1'b0;
    check("busy_ignore_lo_busy", lo, 32'd42);
    drain("busy_ignore");

    // Asynchronous reset in the middle of a multiply.
    issue(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34, "rst_mid");
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi",   hi, 32'd0);
    check("rst_mid_lo",   lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34, "after_rst");
    drain("after_rst");

    if (sb.size() != 0) check("leftover_expectations", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/zmips_muldiv.md
Name: zmips_muldiv

Overview:
- Parametrised, multi-cycle integer multiply/divide unit for the zmips execute stage.
- Sits beside the single-cycle ALU and owns the architectural HI/LO result registers.
- Performs signed/unsigned WIDTH×WIDTH multiply (2·WIDTH product) and signed/unsigned divide (quotient + remainder) by a radix-2 iterative datapath.
- Uses a start/busy/done handshake so the pipeline can stall on it.

Parameters:
- WIDTH, 32, operand and HI/LO width; any even value ≥ 8.
- CW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only when busy=0.
- op  in  2  operation: MULT, MULTU, DIV, DIVU.
- a  in  WIDTH  multiplicand / dividend, sampled on accept.
- b  in  WIDTH  multiplier / divisor, sampled on accept.
- wr_hi  in  1  direct HI write (MTHI).
- wr_lo  in  1  direct LO write (MTLO).
- wdata  in  WIDTH  data for wr_hi/wr_lo.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_zero  out  1  last divide had b=0; valid with done, held until next accept.
- hi  out  WIDTH  multiply: upper product half; divide: remainder.
- lo  out  WIDTH  multiply: lower product half; divide: quotient.

Behaviour:
- Reset: busy=0, done=0, div_zero=0, hi=0, lo=0, state=IDLE.
- Reset mid-operation aborts immediately: no done, and HI/LO are zeroed.
- FSM states: IDLE, RUN, FIX.
  - IDLE: start=1 latches a, b, op and clears div_zero.
    - If op is DIV/DIVU and b=0: go to FIX.
    - Otherwise: go to RUN with counter=WIDTH.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements; at counter=1 go to FIX.
  - FIX: applies sign correction, writes HI/LO, pulses done, returns to IDLE.
- Signed ops work on magnitudes; FIX negates results:
  - Product is negated when the operand signs differ.
  - Quotient is negated when signs differ; quotient truncates toward zero.
  - Remainder takes the dividend's sign.
- Latency:
  - Start accepted in cycle 0.
  - busy=1 in cycles 1..WIDTH+1.
  - done=1 and HI/LO valid in cycle WIDTH+2.
  - busy=0 in the done cycle, so a new start may be accepted there (back-to-back).
- Divide by zero:
  - Skips RUN; done in cycle 2.
  - lo=all ones, hi=a, div_zero=1.
- Overflow: signed MIN / −1 gives lo=MIN, hi=0, div_zero=0.
- start while busy=1 is ignored (not queued).
- wr_hi/wr_lo:
  - Honoured only when busy=0 and the FSM is not in FIX; otherwise ignored.
  - Simultaneous with an accepted start: the write takes effect and is later overwritten by the result.
- Operands are registered on accept; a and b may change freely while busy.

Optional Feature:
- ZMIPS_MULDIV_EARLY_OUT_EN
- Defined: in RUN for MULT/MULTU, when all remaining multiplier bits are zero the FSM goes straight to FIX, with the product aligned by the remaining shift count.
  - Latency becomes variable; minimum done in cycle 3.
  - Divide timing is unchanged.
- Undefined: fixed latency for all ops as above.

Decomposition:
- zmips_pkg holds:
  - Op encodings: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - FSM state encodings: IDLE, RUN, FIX.
- One natural sub-module: zmips_cond_neg (combinational, parametrised WIDTH).
  - Outputs the two's-complement negation of its input when neg=1, else passes it through.
  - Instantiated for operand magnitude conversion and for FIX-stage result correction.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high in cycles 1–33.
- MULT a=0xFFFFFFFD (−3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (−21).
- DIV a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU a=100 b=7 issued in the done cycle → lo=14, hi=2, 34 cycles later.
- DIV a=5 b=0 → done in cycle 2, div_zero=1, lo=0xFFFFFFFF, hi=5; DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- MULTU a=3 b=5, pulse start again at cycle 5 with a=9, and assert wr_lo=1 wdata=0x1234 at cycle 6 → second start and write ignored; result lo=15, hi=0.
- MULTU a=3 b=5, then assert rst at cycle 10 → busy=0, hi=lo=0 asynchronously, no done afterwards; a subsequent MULTU 3×5 → lo=15.
